// File: rtl/falafel_mem_responder_if.sv
// Request/response bus between falafel_lsu (master) and a memory responder (slave).
// Each transaction is one request handshake followed by one response handshake.
interface falafel_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic              mem_req_is_cas_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic [DATA_W-1:0] mem_req_cas_exp_i;
  logic              mem_rsp_val_o;
  logic              mem_rsp_rdy_i;
  logic [DATA_W-1:0] mem_rsp_data_o;

  modport master (
    output mem_req_val_i,
    input  mem_req_rdy_o,
    output mem_req_is_write_i,
    output mem_req_is_cas_i,
    output mem_req_addr_i,
    output mem_req_data_i,
    output mem_req_cas_exp_i,
    input  mem_rsp_val_o,
    output mem_rsp_rdy_i,
    input  mem_rsp_data_o
  );

  modport slave (
    input  mem_req_val_i,
    output mem_req_rdy_o,
    input  mem_req_is_write_i,
    input  mem_req_is_cas_i,
    input  mem_req_addr_i,
    input  mem_req_data_i,
    input  mem_req_cas_exp_i,
    output mem_rsp_val_o,
    input  mem_rsp_rdy_i,
    output mem_rsp_data_o
  );
endinterface

// File: rtl/falafel_mem_responder.sv
// Single-outstanding memory responder: load/store/CAS against a word array,
// answering after a fixed LATENCY. CAS is atomic because nothing else can be in flight.
module falafel_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  falafel_mem_responder_if.slave   bus,
  output logic                     oor_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              oor_q, oor_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] word_full;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] old_word;
  logic              accept;
  logic              cas_hit;
  logic              wr_en;
  logic [DATA_W-1:0] rsp_word;

  assign word_full = bus.mem_req_addr_i >> OFF_W;
  assign in_range  = word_full < DATA_W'(DEPTH);
  assign idx       = word_full[IDX_W-1:0];
  assign old_word  = mem[idx];

  // Ready is a pure function of state (and held low during reset), never of val.
  assign bus.mem_req_rdy_o = (state_q == ST_IDLE) && !rst_i;
  assign accept            = bus.mem_req_val_i && bus.mem_req_rdy_o;
  assign cas_hit           = (old_word == bus.mem_req_cas_exp_i);

  assign wr_en = accept && in_range &&
                 (bus.mem_req_is_cas_i ? cas_hit : bus.mem_req_is_write_i);

  always_comb begin
    rsp_word = '0;
    if (in_range) begin
      if (bus.mem_req_is_cas_i) begin
        rsp_word = old_word;
      end else if (!bus.mem_req_is_write_i) begin
        rsp_word = old_word;
      end
    end
  end

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[idx] <= bus.mem_req_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    oor_d   = oor_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_d   = rsp_word;
          cnt_d   = CNT_W'(LATENCY - 1);
          oor_d   = oor_q || !in_range;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Counter reaching zero on this edge lands the response LATENCY edges after acceptance.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_rsp_rdy_i) begin
          state_d = ST_IDLE;
          rsp_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_rsp_val_o  = (state_q == ST_RESP);
  assign bus.mem_rsp_data_o = (state_q == ST_RESP) ? rsp_q : '0;
  assign oor_o              = oor_q;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Randomized self-checking bench for falafel_mem_responder against a word-array
// reference model of load/store/CAS semantics.
module tb_falafel_mem_responder;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  localparam int OP_LOAD  = 0;
  localparam int OP_STORE = 1;
  localparam int OP_CAS   = 2;
  localparam int OP_BOTH  = 3;

  logic clk_i;
  logic rst_i;
  logic oor_o;

  falafel_mem_responder_if #(.DATA_W(DATA_W)) bus ();

  falafel_mem_responder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave),
    .oor_o(oor_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] modelMem [DEPTH];
  logic              modelOor;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference semantics: word index from byte address, out-of-range drops writes and reads 0.
  function automatic logic [31:0] modelTxn(input int op, input logic [31:0] addr,
                                           input logic [31:0] data, input logic [31:0] exp);
    logic [31:0] idx;
    logic [31:0] old;
    idx = addr / 4;
    if (idx >= DEPTH) begin
      modelOor = 1'b1;
      return 32'h0;
    end
    old = modelMem[idx];
    if (op == OP_LOAD) return old;
    if (op == OP_STORE) begin
      modelMem[idx] = data;
      return 32'h0;
    end
    if (old == exp) modelMem[idx] = data;
    return old;
  endfunction

  task automatic driveRequest(input int op, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] exp);
    bus.mem_req_val_i      = 1'b1;
    bus.mem_req_is_write_i = (op == OP_STORE || op == OP_BOTH);
    bus.mem_req_is_cas_i   = (op == OP_CAS || op == OP_BOTH);
    bus.mem_req_addr_i     = addr;
    bus.mem_req_data_i     = data;
    bus.mem_req_cas_exp_i  = exp;
  endtask

  task automatic scrambleRequest();
    bus.mem_req_val_i      = 1'b0;
    bus.mem_req_is_write_i = 1'($urandom);
    bus.mem_req_is_cas_i   = 1'($urandom);
    bus.mem_req_addr_i     = $urandom;
    bus.mem_req_data_i     = $urandom;
    bus.mem_req_cas_exp_i  = $urandom;
  endtask

  task automatic applyStimulus(input int op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] exp, input int stall, input bit early);
    logic [31:0] expRsp;
    logic [31:0] held;
    int          waitCycles;
    bit          got;

    expRsp = modelTxn(op, addr, data, exp);
    @(negedge clk_i);
    waitCycles = 0;
    while (!bus.mem_req_rdy_o && waitCycles < 20) begin
      @(negedge clk_i);
      waitCycles++;
    end
    checkOutput("req_rdy_idle", 32'(bus.mem_req_rdy_o), 32'h1);
    driveRequest(op, addr, data, exp);
    @(posedge clk_i);
    #1;
    scrambleRequest();
    if (early) bus.mem_rsp_rdy_i = 1'b1;

    waitCycles = 0;
    got        = 1'b0;
    while (!got && waitCycles < 20) begin
      @(negedge clk_i);
      waitCycles++;
      if (bus.mem_rsp_val_o) begin
        got = 1'b1;
      end else begin
        checkOutput("req_rdy_wait", 32'(bus.mem_req_rdy_o), 32'h0);
        checkOutput("rsp_data_idle", bus.mem_rsp_data_o, 32'h0);
      end
    end
    if (!got) begin
      checkOutput("rsp_timeout", 32'(bus.mem_rsp_val_o), 32'h1);
      bus.mem_rsp_rdy_i = 1'b0;
      return;
    end
    checkOutput("latency", 32'(waitCycles), 32'(LATENCY));
    checkOutput("rsp_data", bus.mem_rsp_data_o, expRsp);
    checkOutput("oor", 32'(oor_o), 32'(modelOor));
    held = bus.mem_rsp_data_o;

    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      checkOutput("stall_val", 32'(bus.mem_rsp_val_o), 32'h1);
      checkOutput("stall_data", bus.mem_rsp_data_o, held);
      checkOutput("stall_req_rdy", 32'(bus.mem_req_rdy_o), 32'h0);
    end

    bus.mem_rsp_rdy_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.mem_rsp_rdy_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_rsp_val", 32'(bus.mem_rsp_val_o), 32'h0);
    checkOutput("post_rsp_data", bus.mem_rsp_data_o, 32'h0);
    checkOutput("post_req_rdy", 32'(bus.mem_req_rdy_o), 32'h1);
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic [31:0] idx;
    int          op;
    int          stall;
    bit          early;
    int          waitCycles;

    modelOor          = 1'b0;
    bus.mem_rsp_rdy_i = 1'b0;
    scrambleRequest();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_req_rdy", 32'(bus.mem_req_rdy_o), 32'h0);
    checkOutput("reset_rsp_val", 32'(bus.mem_rsp_val_o), 32'h0);
    checkOutput("reset_rsp_data", bus.mem_rsp_data_o, 32'h0);
    checkOutput("reset_oor", 32'(oor_o), 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_req_rdy", 32'(bus.mem_req_rdy_o), 32'h1);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_STORE, 32'(i * 4), 32'h0, 32'h0, 0, 1'b0);
    end

    applyStimulus(OP_STORE, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    applyStimulus(OP_LOAD,  32'h10, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus(OP_CAS,   32'h20, 32'h5, 32'h0, 0, 1'b0);
    applyStimulus(OP_CAS,   32'h20, 32'h7, 32'h0, 0, 1'b0);
    applyStimulus(OP_LOAD,  32'h20, 32'h0, 32'h0, 4, 1'b0);
    applyStimulus(OP_BOTH,  32'h20, 32'h123, 32'h99, 0, 1'b0);
    applyStimulus(OP_LOAD,  32'h22, 32'h0, 32'h0, 0, 1'b1);
    applyStimulus(OP_LOAD,  32'(DEPTH * 4), 32'h0, 32'h0, 0, 1'b0);
    applyStimulus(OP_STORE, 32'h0, 32'h1, 32'h0, 0, 1'b0);
    applyStimulus(OP_LOAD,  32'h0, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus(OP_STORE, 32'(DEPTH * 8), 32'hFFFF, 32'h0, 0, 1'b0);
    applyStimulus(OP_LOAD,  32'h0, 32'h0, 32'h0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        addr = 32'(DEPTH * 4) + $urandom_range(0, 4096);
      end else begin
        addr = 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
      end
      data = $urandom;
      idx  = addr / 4;
      if (idx < DEPTH && $urandom_range(0, 1) == 1) exp = modelMem[idx];
      else exp = $urandom;
      stall = int'($urandom_range(0, 3));
      early = (stall == 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(op, addr, data, exp, stall, early);
    end

    // Store committed at acceptance must survive a reset that abandons its response.
    void'(modelTxn(OP_STORE, 32'h30, 32'h9, 32'h0));
    modelOor = 1'b0;
    @(negedge clk_i);
    driveRequest(OP_STORE, 32'h30, 32'h9, 32'h0);
    @(posedge clk_i);
    #1;
    scrambleRequest();
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checkOutput("rst_wait_rsp_val", 32'(bus.mem_rsp_val_o), 32'h0);
      checkOutput("rst_wait_req_rdy", 32'(bus.mem_req_rdy_o), 32'h0);
    end
    rst_i = 1'b0;
    waitCycles = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (bus.mem_rsp_val_o) waitCycles++;
    end
    checkOutput("no_rsp_after_rst", 32'(waitCycles), 32'h0);
    checkOutput("rdy_after_rst", 32'(bus.mem_req_rdy_o), 32'h1);
    checkOutput("oor_after_rst", 32'(oor_o), 32'h0);
    applyStimulus(OP_LOAD, 32'h30, 32'h0, 32'h0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
